// File: rtl/mul_slave_param.sv
// Memory-mapped radix-4 Booth multiplier slave.
// Holds WIDTH-bit operands, mode, status and a 2*WIDTH-bit result.
module mul_slave_param #(
  parameter int WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [5:0]  S_address,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout,
  output logic        m_interrupt
);

  localparam int N  = WIDTH / 32;
  localparam int C  = 4 * N;
  localparam int EW = WIDTH + 2;
  localparam int HW = WIDTH + 4;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2 + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0][31:0]   a_q, b_q;
  logic [2*N-1:0][31:0] result_q;
  logic                 mode_q, intr_en_q;

  logic signed [HW-1:0] hi_q;
  logic [EW-1:0]        lo_q;
  logic                 qm1_q;
  logic [EW-1:0]        mcand_q;
  logic [CW-1:0]        cnt_q;

  logic wr, busy, done, start, clear, finish;

  assign wr     = S_sel & S_wr;
  assign busy   = (state_q == EXEC);
  assign done   = (state_q == DONE);
  assign start  = wr && S_address == 6'(C) && S_din[0] && !busy;
  assign clear  = wr && S_address == 6'(C + 1) && S_din[0];
  assign finish = busy && cnt_q == CW'(1);

  assign m_interrupt = done & intr_en_q;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = EXEC;
    end else if (finish) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // One Booth digit per cycle: add 0/+-M/+-2M, then arithmetic shift by 2
  logic signed [HW-1:0] m_ext, addend, sum, hi_n;
  logic [EW-1:0]        lo_n;
  logic [EW-1:0]        a_ext, b_ext;
  logic [2*WIDTH-1:0]   prod;

  always_comb begin
    m_ext  = {{2{mcand_q[EW-1]}}, mcand_q};
    addend = '0;
    unique case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext <<< 1;
      3'b100:         addend = -(m_ext <<< 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum  = hi_q + addend;
    hi_n = sum >>> 2;
    lo_n = {sum[1:0], lo_q[EW-1:2]};
    prod = {hi_n[WIDTH-3:0], lo_n};
    a_ext = {{2{mode_q & a_q[N-1][31]}}, a_q};
    b_ext = {{2{mode_q & b_q[N-1][31]}}, b_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      intr_en_q <= 1'b0;
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      qm1_q     <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
    end else begin
      if (wr && !busy) begin
        for (int i = 0; i < N; i++) begin
          if (S_address == 6'(i)) a_q[i] <= S_din;
          if (S_address == 6'(N + i)) b_q[i] <= S_din;
        end
        if (S_address == 6'(C + 4)) mode_q <= S_din[0];
      end
      if (wr && S_address == 6'(C + 3)) begin
        intr_en_q <= S_din[0];
      end
      if (clear) begin
        result_q <= '0;
        hi_q     <= '0;
        lo_q     <= '0;
        qm1_q    <= 1'b0;
        mcand_q  <= '0;
        cnt_q    <= '0;
      end else if (start) begin
        hi_q    <= '0;
        lo_q    <= b_ext;
        qm1_q   <= 1'b0;
        mcand_q <= a_ext;
        cnt_q   <= CNT_INIT;
      end else if (busy) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        qm1_q <= lo_q[1];
        cnt_q <= cnt_q - CW'(1);
        if (finish) result_q <= prod;
      end
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (S_address == 6'(i)) rdata = a_q[i];
      if (S_address == 6'(N + i)) rdata = b_q[i];
    end
    for (int i = 0; i < 2 * N; i++) begin
      if (S_address == 6'(2 * N + i)) rdata = result_q[i];
    end
    if (S_address == 6'(C + 2)) rdata = {30'b0, busy, done};
    if (S_address == 6'(C + 3)) rdata = {31'b0, intr_en_q};
    if (S_address == 6'(C + 4)) rdata = {31'b0, mode_q};
  end

  assign S_dout = (S_sel && !S_wr) ? rdata : 32'b0;

endmodule

// File: doc/mul_slave_param.md
# mul_slave_param

Parametrised bus-slave multiplier: the next generation of the top-level 64×64 multiplier peripheral. A bus master writes two WIDTH-bit operands and a mode word into memory-mapped registers, starts the operation, then reads back a 2·WIDTH-bit product. The operation completes on interrupt or by polling. New relative to the previous generation: the operand width is parametrised, signed and unsigned modes are both supported, a radix-4 Booth datapath retires 2 bits per cycle, a busy/done status word is readable, and an in-flight operation can be aborted.

## Interface
- WIDTH, 64: operand width in bits; a multiple of 32, range 32..256. N = WIDTH/32 words per operand.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- S_sel  in  1  slave select from the bus decoder.
- S_wr  in  1  1 = write, 0 = read; qualified by S_sel.
- S_address  in  6  word offset within the block.
- S_din  in  32  write data.
- S_dout  out  32  read data; combinational, 0 when S_sel=0 or S_wr=1.
- m_interrupt  out  1  level interrupt, equal to opdone & intr_en.

## Operation
- Register map (C = 4N):
  - A: 0..N-1, read/write.
  - B: N..2N-1, read/write.
  - RESULT: 2N..4N-1, read-only.
  - OPSTART: C+0, write-only, bit0.
  - OPCLEAR: C+1, write-only, bit0.
  - STATUS: C+2, read-only; bit0 = done, bit1 = busy.
  - INTR_EN: C+3, read/write, bit0.
  - MODE: C+4, read/write; bit0 = 1 selects signed two's complement.
- Word ordering is little-endian: the lowest address holds bits [31:0].
- Unmapped offsets read 0; writes to them are ignored.
- A write commits when S_sel & S_wr is high at a rising edge.
- States:
  - IDLE: waits for OPSTART.
  - EXEC: runs the Booth iterations.
  - DONE: product is valid.
- Transitions:
  - IDLE or DONE, on OPSTART bit0=1: go to EXEC. Latch A, B and MODE into working registers, clear done, load counter = WIDTH/2+1.
  - EXEC: decrement the counter each cycle. When it reaches 1, go to DONE, write the product into RESULT and set done.
  - Any state, on OPCLEAR bit0=1: go to IDLE; done=0, RESULT=0, working registers 0. A, B, MODE and INTR_EN are kept.
- Datapath:
  - Operands are extended to WIDTH+2 bits: sign extension when MODE=1, zero extension when MODE=0.
  - Radix-4 Booth recoding of the extended multiplier. Each cycle the partial-product accumulator adds 0, ±M or ±2M, then shifts right arithmetically by 2.
  - The product is the low 2·WIDTH bits of the final accumulator.
- While busy (EXEC), writes to A, B, MODE and OPSTART are ignored. OPCLEAR and INTR_EN writes are accepted.
- RESULT keeps the previous product until the next completion; it is not cleared by OPSTART.
- Boundary rules:
  - OPCLEAR in the same cycle EXEC would finish: clear wins, done stays 0.
  - OPSTART while in DONE restarts the operation and drops done and the interrupt on the next edge.

## Timing
- Reset values:
  - S_dout = 0, m_interrupt = 0.
  - All registers 0; state IDLE.
- OPSTART committed at edge k:
  - busy=1 from edge k.
  - done=1 and RESULT valid at edge k+WIDTH/2+1, which is 33 cycles for WIDTH=64.
  - m_interrupt rises at the same edge as done when INTR_EN=1.
- m_interrupt is held until OPCLEAR, OPSTART, or an INTR_EN write of 0.
- Setting INTR_EN while done=1 raises m_interrupt at the next edge.
- Reads are combinational in the same cycle. The master holds S_sel for at least one cycle per access.
- reset_n low mid-operation aborts immediately to reset values; no partial RESULT is visible.

## Test plan
- WIDTH=64, MODE=0: A=5, B=4, INTR_EN=1, OPSTART → m_interrupt rises 33 cycles later; RESULT words = 0x14, 0, 0, 0; STATUS=0x1.
- MODE=1: A=-3 (0xFFFFFFFF_FFFFFFFD), B=7 → RESULT = 0xFFFF…FFEB (all 128 bits); MODE=0 with the same operands → 0x00000000_00000006_FFFFFFFF_FFFFFFEB.
- MODE=0: A=B=0xFFFFFFFF_FFFFFFFF → RESULT = 0xFFFFFFFF_FFFFFFFE_00000000_00000001; MODE=1 with the same operands → 1.
- Start an operation, write A=9 at cycle 10 of EXEC, then OPCLEAR at cycle 20 → A unchanged, STATUS=0, RESULT=0, m_interrupt stays 0.
- INTR_EN=0, operation completes → m_interrupt=0 and STATUS=0x1; write INTR_EN=1 → m_interrupt=1 next edge; OPCLEAR → 0.
- Rerun with WIDTH=32 and WIDTH=128: -1 × -1 signed = 1; completion latency of 17 and 65 cycles respectively.
